tick_enable_gen: RTL and testbench

- Upstream control stage for nbit_counter: produces its `enable` input.
- Turns two raw ULX3S pushbuttons (run/stop toggle, single-step) into clean one-cycle enable strobes.
- While running, issues one strobe every DIV clocks (prescaler); while stopped, issues one strobe per step press.
- Output drives the counter's `enable` directly; same clock and reset domain as the counter.

---
 rtl/tick_enable_gen.sv | 150 +++++++++++++++
 tb/tb_tick_enable_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tick_enable_gen.sv
// tick_enable_gen: turns raw run/stop and single-step buttons into a one-cycle counter enable.
// The single-step path exists only when TICK_GEN_STEP_EN is defined; otherwise btn_step is ignored.
module tick_enable_gen #(
  parameter int DIV        = 25000000,
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run,
  input  logic btn_step,
  output logic tick,
  output logic running
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);

  // run/stop button: 2-flop synchronizer, debouncer, rising-level press detect
  logic          r_run_s1;
  logic          r_run_s2;
  logic          r_run_deb;
  logic          r_run_deb_d;
  logic [DW-1:0] r_run_cnt;
  logic          w_press_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_run_deb   <= 1'b0;
      r_run_deb_d <= 1'b0;
      r_run_cnt   <= '0;
    end else begin
      r_run_s1    <= btn_run;
      r_run_s2    <= r_run_s1;
      r_run_deb_d <= r_run_deb;
      if (r_run_s2 == r_run_deb) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt == D_LAST) begin
        r_run_deb <= r_run_s2;
        r_run_cnt <= '0;
      end else begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end
  end

  assign w_press_run = r_run_deb & ~r_run_deb_d;

`ifdef TICK_GEN_STEP_EN
  logic          r_step_s1;
  logic          r_step_s2;
  logic          r_step_deb;
  logic          r_step_deb_d;
  logic [DW-1:0] r_step_cnt;
  logic          w_press_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_s1    <= 1'b0;
      r_step_s2    <= 1'b0;
      r_step_deb   <= 1'b0;
      r_step_deb_d <= 1'b0;
      r_step_cnt   <= '0;
    end else begin
      r_step_s1    <= btn_step;
      r_step_s2    <= r_step_s1;
      r_step_deb_d <= r_step_deb;
      if (r_step_s2 == r_step_deb) begin
        r_step_cnt <= '0;
      end else if (r_step_cnt == D_LAST) begin
        r_step_deb <= r_step_s2;
        r_step_cnt <= '0;
      end else begin
        r_step_cnt <= r_step_cnt + 1'b1;
      end
    end
  end

  assign w_press_step = r_step_deb & ~r_step_deb_d;
`else
  logic w_step_unused;
  assign w_step_unused = btn_step;
`endif

  // state      | meaning
  // ST_STOPPED | prescaler parked at 0; tick only from a step press
  // ST_RUNNING | prescaler free-runs; tick after each prescaler terminal count
  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_STOPPED;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          r_presc <= '0;
          if (w_press_run) begin
            r_state   <= ST_RUNNING;
            r_running <= 1'b1;
            r_tick    <= 1'b0;
          end
`ifdef TICK_GEN_STEP_EN
          else if (w_press_step) begin
            r_tick <= 1'b1;
          end
`endif
          else begin
            r_tick <= 1'b0;
          end
        end
        ST_RUNNING: begin
          // a stop press wins even over a tick that is due this cycle
          if (w_press_run) begin
            r_state   <= ST_STOPPED;
            r_running <= 1'b0;
            r_presc   <= '0;
            r_tick    <= 1'b0;
          end else begin
            r_tick  <= (r_presc == P_LAST);
            r_presc <= (r_presc == P_LAST) ? '0 : r_presc + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_STOPPED;
          r_running <= 1'b0;
          r_presc   <= '0;
          r_tick    <= 1'b0;
        end
      endcase
    end
  end

  assign tick    = r_tick;
  assign running = r_running;

endmodule

// File: tb/tb_tick_enable_gen.sv
// Scoreboarded bench for tick_enable_gen with DIV=4, DEB_CYCLES=3.
// Build with or without TICK_GEN_STEP_EN; step-tick expectations follow the macro.
`timescale 1ns/1ps
module tb_tick_enable_gen;

  localparam int DIV = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic tick;
  logic running;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_ticks = 0;

  typedef struct {
    int   at;
    logic run;
  } exp_t;

  exp_t sb[$];

  tick_enable_gen #(.DIV(DIV), .DEB_CYCLES(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .tick     (tick),
    .running  (running)
  );

  always #500 clk = ~clk;

  always @(posedge clk) cyc++;

  // monitor: every observed tick must match the oldest expected tick
  always @(negedge clk) begin : mon
    exp_t e;
    if (tick === 1'b1) begin
      n_ticks++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_tick: tick seen at cycle %0d, none expected", cyc);
      end else begin
        e = sb.pop_front();
        if (cyc < e.at - 1 || cyc > e.at + 1 || running !== e.run) begin
          n_errors++;
          $display("FAIL tick_match: tick at cycle %0d running=%0b, expected cycle %0d running=%0b",
                   cyc, running, e.at, e.run);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input int at, input logic run);
    exp_t e;
    e.at  = at;
    e.run = run;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    int s;
    int p;
    int t0;

    // reset held while buttons toggle
    rst_n = 1'b0;
    repeat (10) begin
      @(negedge clk);
      btn_run  = ~btn_run;
      btn_step = 1'($urandom_range(0, 1));
      chk("reset_tick", int'(tick), 0);
      chk("reset_running", int'(running), 0);
    end
    btn_run  = 1'b0;
    btn_step = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_running", int'(running), 0);

    // run press: running at n+6, ticks every 4 cycles from n+10; stop press at n+41 lands at n+47
    @(negedge clk);
    n = cyc;
    btn_run = 1'b1;
    for (int k = 0; k < 10; k++) push(n + 10 + 4 * k, 1'b1);
    goto(n + 4);
    chk("run_not_yet", int'(running), 0);
    goto(n + 7);
    chk("run_entered", int'(running), 1);
    goto(n + 9);
    t0 = n_ticks;
    goto(n + 10);
    btn_run = 1'b0;
    goto(n + 29);
    chk("run_window_ticks", n_ticks - t0, 5);

    // 2-cycle glitch must be rejected
    goto(n + 30);
    btn_run = 1'b1;
    goto(n + 32);
    btn_run = 1'b0;
    goto(n + 39);
    chk("glitch_rejected", int'(running), 1);

    // real stop press
    goto(n + 41);
    btn_run = 1'b1;
    goto(n + 46);
    chk("stop_not_yet", int'(running), 1);
    goto(n + 48);
    chk("stopped", int'(running), 0);
    goto(n + 51);
    btn_run = 1'b0;
    goto(n + 70);
    chk("run_ticks_all_seen", sb.size(), 0);

    // three single-step presses while stopped
    s = n + 75;
    goto(s - 1);
    t0 = n_ticks;
    for (int i = 0; i < 3; i++) begin
      goto(s + 20 * i);
      btn_step = 1'b1;
`ifdef TICK_GEN_STEP_EN
      push(s + 20 * i + 6, 1'b0);
`endif
      goto(s + 20 * i + 10);
      btn_step = 1'b0;
    end
    goto(s + 65);
`ifdef TICK_GEN_STEP_EN
    chk("step_tick_count", n_ticks - t0, 3);
`else
    chk("step_tick_count", n_ticks - t0, 0);
`endif
    chk("step_running", int'(running), 0);

    // run and step rise together: run wins, no step tick, first tick 4 cycles after running
    p = s + 70;
    goto(p);
    btn_run  = 1'b1;
    btn_step = 1'b1;
    push(p + 10, 1'b1);
    push(p + 14, 1'b1);
    goto(p + 5);
    chk("both_not_yet", int'(running), 0);
    goto(p + 7);
    chk("both_running", int'(running), 1);
    goto(p + 10);
    btn_run  = 1'b0;
    btn_step = 1'b0;

    // reset asserted while a tick is on the output
    goto(p + 14);
    chk("tick_before_rst", int'(tick), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drops_tick", int'(tick), 0);
    chk("rst_drops_running", int'(running), 0);
    goto(p + 20);
    rst_n = 1'b1;
    goto(p + 45);
    chk("post_rst_running", int'(running), 0);
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
